// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the BRAM arbiter: owner ids, bus widths and
// the winner select used by the grant logic.
package mem_arbiter_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;

    typedef logic [1:0] own_t;

    localparam own_t OWN_NONE = 2'd0;
    localparam own_t OWN_IF   = 2'd1;
    localparam own_t OWN_EX   = 2'd2;
    localparam own_t OWN_LD   = 2'd3;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LD   = 2'd1,
        SEL_EX   = 2'd2,
        SEL_IF   = 2'd3
    } sel_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the BRAM arbiter: loader, exec and fetch handshakes.
// master = the requesting units, slave = the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;

    logic              ex_req;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic [3:0]        ex_wea;
    logic              ex_gnt;
    logic              ex_rvalid;
    logic [DATA_W-1:0] ex_rdata;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output ex_req, ex_addr, ex_wdata, ex_wea,
        output if_req, if_addr,
        input  ld_gnt, ex_gnt, ex_rvalid, ex_rdata,
        input  if_gnt, if_rvalid, if_rdata
    );

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  ex_req, ex_addr, ex_wdata, ex_wea,
        input  if_req, if_addr,
        output ld_gnt, ex_gnt, ex_rvalid, ex_rdata,
        output if_gnt, if_rvalid, if_rdata
    );

endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Shift register of read owner ids that tracks reads through the BRAM latency;
// the tag leaving the head decides which requester gets the rvalid pulse.
module rd_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rstn,
    input  own_t push_tag,
    output logic if_rvalid,
    output logic ex_rvalid,
    output logic any_busy
);

    own_t [RD_LAT-1:0] tag_q;
    own_t [RD_LAT-1:0] tag_d;
    own_t              head_s;

    // Next-state: new tag enters stage 0, older tags move one stage along
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = push_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipeline register; reset drops every read still in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Head decode and in-flight detection
    always_comb begin
        head_s    = tag_q[RD_LAT-1];
        if_rvalid = (head_s == OWN_IF);
        ex_rvalid = (head_s == OWN_EX);
        any_busy  = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (tag_q[i] != OWN_NONE) begin
                any_busy = 1'b1;
            end else begin
                any_busy = any_busy;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter for loader, exec and fetch: one access per cycle,
// priority ld > ex > if with a fetch starvation guard, tagged read returns.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    mem_arbiter_if.slave      req_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wea,
    output logic              mem_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    sel_e              sel_s;
    own_t              push_tag_s;
    logic              tags_busy_s;
    logic              if_rvalid_s;
    logic              ex_rvalid_s;

    // Winner selection; a saturated wait counter lets fetch jump ahead of exec
    always_comb begin
        sel_s = SEL_NONE;
        if (!rstn) begin
            sel_s = SEL_NONE;
        end else if (req_if.ld_req) begin
            sel_s = SEL_LD;
        end else if (req_if.if_req && (wait_cnt_q == WAIT_MAX)) begin
            sel_s = SEL_IF;
        end else if (req_if.ex_req) begin
            sel_s = SEL_EX;
        end else if (req_if.if_req) begin
            sel_s = SEL_IF;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // BRAM drive, grant pulses and read-owner tag for the selected winner
    always_comb begin
        mem_addr   = {ADDR_W{1'b0}};
        mem_wdata  = {DATA_W{1'b0}};
        mem_wea    = 4'b0000;
        push_tag_s = OWN_NONE;
        case (sel_s)
            SEL_LD: begin
                mem_addr  = req_if.ld_addr;
                mem_wdata = req_if.ld_wdata;
                mem_wea   = 4'b1111;
            end
            SEL_EX: begin
                mem_addr  = req_if.ex_addr;
                mem_wdata = req_if.ex_wdata;
                mem_wea   = req_if.ex_wea;
                if (req_if.ex_wea == 4'b0000) begin
                    push_tag_s = OWN_EX;
                end else begin
                    push_tag_s = OWN_NONE;
                end
            end
            SEL_IF: begin
                mem_addr   = req_if.if_addr;
                push_tag_s = OWN_IF;
            end
            default: begin
                mem_addr   = {ADDR_W{1'b0}};
                push_tag_s = OWN_NONE;
            end
        endcase
    end

    // Fetch wait counter next state: saturating count of denied fetch cycles
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (req_if.if_req && (sel_s != SEL_IF)) begin
            if (wait_cnt_q < WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end
    end

    // Fetch wait counter register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .push_tag  (push_tag_s),
        .if_rvalid (if_rvalid_s),
        .ex_rvalid (ex_rvalid_s),
        .any_busy  (tags_busy_s)
    );

    assign req_if.ld_gnt    = (sel_s == SEL_LD);
    assign req_if.ex_gnt    = (sel_s == SEL_EX);
    assign req_if.if_gnt    = (sel_s == SEL_IF);
    assign req_if.if_rvalid = if_rvalid_s;
    assign req_if.ex_rvalid = ex_rvalid_s;
    assign req_if.if_rdata  = mem_rdata;
    assign req_if.ex_rdata  = mem_rdata;
    assign mem_enable       = 1'b1;
    assign busy = req_if.ld_req | req_if.ex_req | req_if.if_req | tags_busy_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-cycle-latency BRAM model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic              clk;
    logic              rstn;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wea;
    logic              mem_enable;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              mem_init;
    logic [DATA_W-1:0] bram [0:31];
    logic [DATA_W-1:0] rd_stage;
    int                checks;
    int                failures;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .RD_LAT   (2),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_if     (bus),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wea    (mem_wea),
        .mem_enable (mem_enable),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: byte-enable write, read-first, two-cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) bram[i] <= 32'h0000_0000;
            bram[0]  <= 32'h1000_0000;
            bram[1]  <= 32'h1111_0001;
            bram[2]  <= 32'h2222_0002;
            bram[16] <= 32'hDEAD_BEEF;
        end else if (mem_enable) begin
            if (mem_wea[0]) bram[mem_addr[4:0]][7:0]   <= mem_wdata[7:0];
            if (mem_wea[1]) bram[mem_addr[4:0]][15:8]  <= mem_wdata[15:8];
            if (mem_wea[2]) bram[mem_addr[4:0]][23:16] <= mem_wdata[23:16];
            if (mem_wea[3]) bram[mem_addr[4:0]][31:24] <= mem_wdata[31:24];
        end
        rd_stage  <= bram[mem_addr[4:0]];
        mem_rdata <= rd_stage;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pipe_exp [0:2];
        pipe_exp[0] = 32'h1000_0000;
        pipe_exp[1] = 32'h1111_0001;
        pipe_exp[2] = 32'h2222_0002;
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        mem_init = 1'b1;
        bus.ld_req = 1'b0; bus.ld_addr = 19'h0; bus.ld_wdata = 32'h0;
        bus.ex_req = 1'b0; bus.ex_addr = 19'h0; bus.ex_wdata = 32'h0; bus.ex_wea = 4'b0000;
        bus.if_req = 1'b0; bus.if_addr = 19'h0;
        next_cycle();
        next_cycle();
        mem_init = 1'b0;

        // Reset: requests present but nothing granted
        bus.ld_req = 1'b1; bus.ex_req = 1'b1; bus.if_req = 1'b1;
        sample();
        check("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
        check("rst_ex_gnt", 32'(bus.ex_gnt), 32'd0);
        check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("rst_mem_wea", 32'(mem_wea), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd1);
        check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("rst_ex_rvalid", 32'(bus.ex_rvalid), 32'd0);
        check("rst_busy_req", 32'(busy), 32'd1);
        next_cycle();
        bus.ld_req = 1'b0; bus.ex_req = 1'b0; bus.if_req = 1'b0;
        sample();
        check("rst_busy_idle", 32'(busy), 32'd0);
        next_cycle();
        rstn = 1'b1;

        // Single exec read
        bus.ex_req = 1'b1; bus.ex_addr = 19'h00010; bus.ex_wea = 4'b0000;
        sample();
        check("rd_ex_gnt", 32'(bus.ex_gnt), 32'd1);
        check("rd_mem_addr", 32'(mem_addr), 32'h10);
        check("rd_mem_wea", 32'(mem_wea), 32'd0);
        next_cycle();
        bus.ex_req = 1'b0;
        sample();
        check("rd_rvalid_early", 32'(bus.ex_rvalid), 32'd0);
        check("rd_busy_inflight", 32'(busy), 32'd1);
        next_cycle();
        sample();
        check("rd_ex_rvalid", 32'(bus.ex_rvalid), 32'd1);
        check("rd_ex_rdata", bus.ex_rdata, 32'hDEAD_BEEF);
        check("rd_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        next_cycle();
        sample();
        check("rd_rvalid_once", 32'(bus.ex_rvalid), 32'd0);
        check("rd_busy_done", 32'(busy), 32'd0);
        next_cycle();

        // Priority ld > ex > if
        bus.ld_req = 1'b1; bus.ld_addr = 19'h5; bus.ld_wdata = 32'h55AA_55AA;
        bus.ex_req = 1'b1; bus.ex_addr = 19'h10; bus.ex_wea = 4'b0000;
        bus.if_req = 1'b1; bus.if_addr = 19'h1;
        sample();
        check("pri_ld_gnt", 32'(bus.ld_gnt), 32'd1);
        check("pri_ld_ex_gnt", 32'(bus.ex_gnt), 32'd0);
        check("pri_ld_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("pri_ld_wea", 32'(mem_wea), 32'hF);
        check("pri_ld_addr", 32'(mem_addr), 32'h5);
        check("pri_ld_wdata", mem_wdata, 32'h55AA_55AA);
        next_cycle();
        bus.ld_req = 1'b0;
        sample();
        check("pri_ex_gnt", 32'(bus.ex_gnt), 32'd1);
        check("pri_ex_if_gnt", 32'(bus.if_gnt), 32'd0);
        next_cycle();
        bus.ex_req = 1'b0;
        sample();
        check("pri_if_gnt", 32'(bus.if_gnt), 32'd1);
        check("pri_if_addr", 32'(mem_addr), 32'h1);
        next_cycle();
        bus.if_req = 1'b0;
        sample();
        check("pri_ex_rvalid", 32'(bus.ex_rvalid), 32'd1);
        check("pri_ex_rdata", bus.ex_rdata, 32'hDEAD_BEEF);
        next_cycle();
        sample();
        check("pri_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("pri_if_rdata", bus.if_rdata, 32'h1111_0001);
        check("pri_if_ex_rvalid", 32'(bus.ex_rvalid), 32'd0);
        next_cycle();

        // Starvation guard: exec writes every cycle, fetch held
        bus.ex_req = 1'b1; bus.ex_addr = 19'h14; bus.ex_wea = 4'b1111; bus.ex_wdata = 32'h7777_7777;
        bus.if_req = 1'b1; bus.if_addr = 19'h2;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("stv_ex_wins", 32'(bus.ex_gnt), 32'd1);
            check("stv_if_denied", 32'(bus.if_gnt), 32'd0);
            next_cycle();
        end
        sample();
        check("stv_if_forced", 32'(bus.if_gnt), 32'd1);
        check("stv_ex_held", 32'(bus.ex_gnt), 32'd0);
        check("stv_if_addr", 32'(mem_addr), 32'h2);
        check("stv_if_wea", 32'(mem_wea), 32'd0);
        next_cycle();
        bus.if_req = 1'b0;
        sample();
        check("stv_ex_resumes", 32'(bus.ex_gnt), 32'd1);
        next_cycle();
        bus.ex_req = 1'b0;
        sample();
        check("stv_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("stv_if_rdata", bus.if_rdata, 32'h2222_0002);
        check("stv_no_ex_rvalid", 32'(bus.ex_rvalid), 32'd0);
        next_cycle();

        // Byte store then fetch read of the same word
        bus.ex_req = 1'b1; bus.ex_addr = 19'h3; bus.ex_wea = 4'b0100; bus.ex_wdata = 32'hABAB_ABAB;
        sample();
        check("bs_ex_gnt", 32'(bus.ex_gnt), 32'd1);
        check("bs_mem_wea", 32'(mem_wea), 32'h4);
        next_cycle();
        bus.ex_req = 1'b0; bus.ex_wea = 4'b0000;
        bus.if_req = 1'b1; bus.if_addr = 19'h3;
        sample();
        check("bs_if_gnt", 32'(bus.if_gnt), 32'd1);
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();
        sample();
        check("bs_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("bs_if_rdata", bus.if_rdata, 32'h00AB_0000);
        check("bs_no_ex_rvalid", 32'(bus.ex_rvalid), 32'd0);
        next_cycle();

        // Pipelined fetch reads of addresses 0,1,2
        for (int i = 0; i < 6; i++) begin
            bus.if_req  = (i < 3);
            bus.if_addr = 19'(i);
            sample();
            if (i < 3) begin
                check("pipe_if_gnt", 32'(bus.if_gnt), 32'd1);
                check("pipe_mem_addr", 32'(mem_addr), 32'(i));
            end
            if (i >= 2 && i < 5) begin
                check("pipe_if_rvalid", 32'(bus.if_rvalid), 32'd1);
                check("pipe_if_rdata", bus.if_rdata, pipe_exp[i-2]);
            end else begin
                check("pipe_if_rvalid_low", 32'(bus.if_rvalid), 32'd0);
            end
            next_cycle();
        end

        // Reset in the cycle after an exec read is granted
        bus.ex_req = 1'b1; bus.ex_addr = 19'h10; bus.ex_wea = 4'b0000;
        sample();
        check("mr_ex_gnt", 32'(bus.ex_gnt), 32'd1);
        next_cycle();
        bus.ex_req = 1'b0;
        rstn = 1'b0;
        sample();
        check("mr_rst_ex_rvalid", 32'(bus.ex_rvalid), 32'd0);
        next_cycle();
        rstn = 1'b1;
        sample();
        check("mr_ex_rvalid_dropped", 32'(bus.ex_rvalid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        next_cycle();
        sample();
        check("mr_ex_rvalid_late", 32'(bus.ex_rvalid), 32'd0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
